// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, defaults and fault check for the instruction fetch sequencer.
package fetch_pkg;
   typedef enum logic [1:0] {FETCH, LOAD, RESTART} state_t;
   localparam int ADDR_W_DFLT = 5;
   localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
   function automatic logic addr_fault(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction
endpackage

// File: rtl/pc_word_addr.sv
// pc_word_addr: maps a byte address to a memory word address and flags misaligned/out-of-range.
module pc_word_addr
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT
) (
   input  logic [31:0]       addr,
   output logic [ADDR_W-1:0] word,
   output logic              fault
);
   assign word  = addr[ADDR_W+1:2];
   assign fault = addr_fault(addr, ADDR_W);
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer owning the program memory port, with loader arbitration.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = ADDR_W_DFLT,
   parameter logic [31:0] RESET_PC = RESET_PC_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic              load_gnt,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_we,
   output logic [31:0]       rom_wdata,
   input  logic [31:0]       rom_rdata,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   output logic              fetch_fault
);
   state_t            state, state_next;
   logic [31:0]       pc, issue_addr;
   logic [ADDR_W-1:0] issue_word;
   logic              issue_fault, issue, hold;
   pc_word_addr #(.ADDR_W(ADDR_W)) u_map (
      .addr (issue_addr),
      .word (issue_word),
      .fault(issue_fault)
   );
   always_comb begin
      state_next = state;
      hold       = stall && instr_valid && !branch_taken;
      issue_addr = branch_taken ? branch_target : hold ? instr_pc : pc;
      issue      = (state == FETCH) && !load_req;
      rom_we     = (state == LOAD) && load_req;
      state_next = (state == FETCH && load_req) ? LOAD :
                   (state == LOAD && !load_req) ? RESTART :
                   (state == RESTART) ? FETCH : state;
   end
   assign load_gnt  = (state == LOAD);
   assign rom_addr  = (state == LOAD) ? load_addr : issue_word;
   assign rom_wdata = rom_we ? load_data : 32'd0;
   assign instr     = rom_rdata;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr_pc    <= RESET_PC;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         state       <= state_next;
         instr_valid <= issue;
         if (issue && !hold) begin
            instr_pc <= issue_addr;
            pc       <= issue_addr + 32'd4;
         end
         if (issue) fetch_fault <= fetch_fault | issue_fault;
         // Load completion restarts fetch cleanly from the reset vector.
         if (state == LOAD && !load_req) begin
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed plus randomized checks of the fetch sequencer against a behavioural model.
module tb_imem_fetch_ctrl;
   localparam int AW = 5;
   logic          clk = 1'b0, reset = 1'b0, stall = 1'b0, branch_taken = 1'b0, load_req = 1'b0;
   logic [31:0]   branch_target = 32'd0, load_data = 32'd0, rom_rdata = 32'd0;
   logic [AW-1:0] load_addr = '0;
   logic          load_gnt, rom_we, instr_valid, fetch_fault;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_wdata, instr, instr_pc;
   imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .load_req(load_req), .load_addr(load_addr),
      .load_data(load_data), .load_gnt(load_gnt), .rom_addr(rom_addr), .rom_we(rom_we),
      .rom_wdata(rom_wdata), .rom_rdata(rom_rdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .fetch_fault(fetch_fault)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] init_word(input int i);
      return 32'h1000_0000 + i;
   endfunction
   // Synchronous program memory; unwritten words read their preload pattern.
   logic [31:0] mem [32];
   bit          written [32];
   always @(posedge clk) begin
      if (rom_we) begin
         mem[rom_addr]     <= rom_wdata;
         written[rom_addr] <= 1'b1;
      end
      rom_rdata <= written[rom_addr] ? mem[rom_addr] : init_word(int'(rom_addr));
   end
   int          tests = 0, fails = 0;
   int          mode;
   logic [31:0] m_pc, m_ipc;
   bit          m_val, m_fault;
   logic [31:0] ref_mem [32];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic bit bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd128);
   endfunction
   task automatic model_reset();
      mode = 0; m_pc = 32'h0; m_ipc = 32'h0; m_val = 0; m_fault = 0;
   endtask
   task automatic step(input bit s, input bit b, input logic [31:0] t, input bit lr,
                       input logic [AW-1:0] la, input logic [31:0] ld);
      logic [31:0] a;
      stall = s; branch_taken = b; branch_target = t; load_req = lr; load_addr = la; load_data = ld;
      #1;
      chk("valid", instr_valid, m_val);
      chk("fault", fetch_fault, m_fault);
      chk("gnt", load_gnt, mode == 1);
      if (m_val) begin
         chk("instr_pc", instr_pc, m_ipc);
         chk("instr", instr, ref_mem[m_ipc[6:2]]);
      end
      a = b ? t : (s && m_val) ? m_ipc : m_pc;
      if (mode == 1) begin
         chk("rom_we", rom_we, lr);
         if (lr) begin
            chk("rom_addr_ld", rom_addr, la);
            chk("rom_wdata_ld", rom_wdata, ld);
         end
      end else begin
         chk("rom_we", rom_we, 0);
         chk("rom_wdata", rom_wdata, 0);
         if (mode == 0 && !lr) chk("rom_addr", rom_addr, a[6:2]);
      end
      case (mode)
         0: if (lr) begin
               mode = 1; m_val = 0;
            end else begin
               if (b || !(s && m_val)) begin
                  m_ipc = a; m_pc = a + 32'd4;
               end
               m_val = 1;
               m_fault = m_fault | bad(a);
            end
         1: if (lr) ref_mem[la] = ld;
            else begin
               mode = 2; m_pc = 32'h0; m_fault = 0;
            end
         default: mode = 0;
      endcase
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, '0, 32'h0);
   endtask
   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
      #1 reset = 1'b1;
      #1;
      chk("rst_gnt", load_gnt, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      idle(3);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, '0, 32'h0);
      idle(2);
      step(1, 0, 32'h0, 0, '0, 32'h0);
      step(1, 1, 32'h40, 0, '0, 32'h0);
      idle(2);
      for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, AW'(i), 32'hA0 + i);
      step(0, 0, 32'h0, 1, '0, 32'h0);
      idle(5);
      step(0, 1, 32'h42, 0, '0, 32'h0);
      idle(2);
      step(0, 1, 32'h80, 0, '0, 32'h0);
      idle(2);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t;
         bit          lr;
         t  = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 31)) << 2);
         lr = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, t, lr, AW'($urandom), $urandom);
      end
      idle(3);
      step(0, 1, 32'h42, 0, '0, 32'h0);
      step(0, 0, 32'h0, 1, '0, 32'h0);
      step(0, 0, 32'h0, 1, 5'd7, 32'hDEAD_BEEF);
      load_req = 1'b1; load_addr = 5'd8; load_data = 32'h1234_5678;
      #2 reset = 1'b1;
      #1;
      chk("amid_gnt", load_gnt, 0);
      chk("amid_we", rom_we, 0);
      chk("amid_valid", instr_valid, 0);
      chk("amid_fault", fetch_fault, 0);
      model_reset();
      load_req = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(6);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
